systolic_array_core: RTL and testbench
======================================

Name: systolic_array_core

Overview:
- Output-stationary N x N systolic matrix-multiply core: computes C = A x B, with A of size N x K and B of size K x N.
- Signed DW-bit operands are streamed in one k-slice per cycle; 32-bit accumulators sit in each PE.
- Results are read out serially, one word per read strobe, row-major.
- Sits between the operand-fetch buffers and the result-drain logic of the accelerator.

Parameters:
- N, 4, array dimension (N x N PEs).
- DW, 8, signed operand width.
- ACCW, 32, accumulator and result width; must equal the routport width.

Ports:
- clk  in  1  single clock, all state updates on its rising edge.
- rstn  in  1  asynchronous, active-high reset; the name follows the codebase, but the polarity is high.
- fire  in  1  start pulse; accepted only in IDLE.
- a_col  in  N*DW  A[i][k] for i=0..N-1; lane i is bits [i*DW +: DW].
- b_row  in  N*DW  B[k][j] for j=0..N-1; lane j is bits [j*DW +: DW].
- in_valid  in  1  a_col/b_row hold a valid k-slice this cycle.
- in_last  in  1  qualifies the final k-slice; meaningful only with in_valid.
- r_read  in  1  read strobe; consumes the current result word.
- routport  out  ACCW  current result word C[idx/N][idx%N].
- rvalidport  out  1  routport holds a valid result.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset, asynchronous, with rstn=1:
  - state=IDLE, all accumulators=0, skew registers=0, read index=0.
  - routport=0, rvalidport=0, busy=0.
  - Reset mid-operation abandons the operation with no residual state.
- States: IDLE -> LOAD -> DRAIN -> READ -> IDLE.
- IDLE:
  - fire=1 clears all accumulators and skew pipelines and enters LOAD on the next cycle.
  - All other inputs are ignored.
- LOAD:
  - Each cycle with in_valid=1, lane i of a_col enters row i through an i-stage delay, and lane j of b_row enters column j through a j-stage delay.
  - Operands then move one PE per cycle: A values rightward, B values downward.
  - Each PE(i,j) computes acc += sext(a)*sext(b) when both of its operand-valid tags are set.
  - in_valid=0 injects a bubble (valid tag 0); the result is unchanged by bubbles.
  - in_valid=1 with in_last=1 moves to DRAIN after accepting that slice.
  - fire is ignored in LOAD.
- DRAIN:
  - Lasts exactly 2N-1 cycles (7 for N=4); only bubbles are injected.
  - Then enters READ with idx=0.
  - rvalidport rises on the first READ cycle.
- READ:
  - rvalidport=1 and routport=C[idx], registered and stable until consumed.
  - r_read=1 at a clock edge advances idx by 1.
  - The r_read that consumes idx=N*N-1 returns the core to IDLE.
  - rvalidport and routport then return to 0 on the following cycle.
  - r_read may be held high for back-to-back reads, one word per cycle.
- r_read outside READ, or with rvalidport=0, is ignored.
- Arithmetic:
  - Product is 2*DW signed.
  - Sign-extend to ACCW and add with two's-complement wrap; no saturation or overflow flag.
- K is any value >= 1; K is not bounded by N.
- Simultaneous fire and in_valid in IDLE: fire is taken and the slice is ignored; the first slice counted is the one in the LOAD state.
- Result readout order is row-major: C[0][0], C[0][1], ..., C[N-1][N-1].

Test Plan:
- Identity: reset, fire, then stream K=4 slices with a_col = column k of I4 and b_row = row k of B, where B = rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}, last slice with in_last. Required: rvalidport rises 7 cycles after DRAIN entry, and 16 r_read pulses yield 1..16 in order. After the final read, busy=0 and rvalidport=0.
- Signed extremes: all A=-128 (0x80), all B=-128, K=4. Every result = 65536 (0x00010000). A second run with A=-128 and B=127 gives every result = -65024 (0xFFFF0200).
- Bubbles: repeat the identity test with in_valid low for 3 cycles between each pair of slices. Required: same outputs 1..16.
- Control ignores:
  - fire pulsed during LOAD and READ has no effect.
  - r_read pulsed in IDLE and LOAD does not change the results.
  - Reading paced every 5 cycles holds each routport value stable until consumed.
- Reset mid-operation: assert rstn=1 during DRAIN. Required: rvalidport=0, routport=0 and busy=0 immediately. A subsequent full identity run gives correct results with no leftover accumulation.
- K=1 single slice: a_col={1,2,3,4} and b_row={10,20,30,40} with in_last. Required: C[i][j]=(i+1)*(j+1)*10, e.g. C[3][3]=160.

Source files
------------

// File: rtl/systolic_array_core.sv
// Output-stationary N x N systolic matrix multiplier: C = A x B with skewed operand entry,
// per-PE 32-bit accumulation and serial row-major readout of the result words.
module systolic_array_core #(
    parameter int N    = 4,
    parameter int DW   = 8,
    parameter int ACCW = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              fire,
    input  logic [N*DW-1:0]   a_col,
    input  logic [N*DW-1:0]   b_row,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic              r_read,
    output logic [ACCW-1:0]   routport,
    output logic              rvalidport,
    output logic              busy
);
    localparam int IDXW = $clog2(N*N);
    localparam int DCW  = $clog2(2*N);
    localparam logic [DCW-1:0]  DRAIN_LAST = DCW'(2*N - 2);
    localparam logic [IDXW-1:0] IDX_LAST   = IDXW'(N*N - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_READ  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [DCW-1:0]      drain_cnt_q, drain_cnt_d;
    logic [IDXW-1:0]     idx_q, idx_d;
    logic [IDXW-1:0]     idx_nx_s;
    logic [ACCW-1:0]     rout_q, rout_d;
    logic                rvalid_q, rvalid_d;
    logic                busy_q, busy_d;

    logic                start_s;
    logic                inject_s;

    // Operands at the array edge after skewing, and operands leaving each PE.
    logic signed [DW-1:0] a_edge_s   [N];
    logic                 a_edge_v_s [N];
    logic signed [DW-1:0] b_edge_s   [N];
    logic                 b_edge_v_s [N];
    logic signed [DW-1:0] a_pe_s     [N][N-1];
    logic                 a_pe_v_s   [N][N-1];
    logic signed [DW-1:0] b_pe_s     [N-1][N];
    logic                 b_pe_v_s   [N-1][N];
    logic [ACCW-1:0]      acc_s      [N*N];

    assign start_s  = (state_q == S_IDLE) && fire;
    assign inject_s = (state_q == S_LOAD) && in_valid;
    assign idx_nx_s = idx_q + IDXW'(1);

    genvar gi, gj;
    generate
        for (gi = 0; gi < N; gi++) begin : g_skew
            logic signed [DW-1:0] a_lane_s;
            logic signed [DW-1:0] b_lane_s;

            assign a_lane_s = inject_s ? a_col[gi*DW +: DW] : {DW{1'b0}};
            assign b_lane_s = inject_s ? b_row[gi*DW +: DW] : {DW{1'b0}};

            if (gi == 0) begin : g_direct
                assign a_edge_s[gi]   = a_lane_s;
                assign a_edge_v_s[gi] = inject_s;
                assign b_edge_s[gi]   = b_lane_s;
                assign b_edge_v_s[gi] = inject_s;
            end else begin : g_delay
                logic signed [DW-1:0] sa_q [gi];
                logic signed [DW-1:0] sa_d [gi];
                logic                 sav_q [gi];
                logic                 sav_d [gi];
                logic signed [DW-1:0] sb_q [gi];
                logic signed [DW-1:0] sb_d [gi];
                logic                 sbv_q [gi];
                logic                 sbv_d [gi];

                // Lane gi is delayed gi cycles; start wipes any stale operands.
                always_comb begin
                    if (start_s) begin
                        sa_d[0]  = {DW{1'b0}};
                        sav_d[0] = 1'b0;
                        sb_d[0]  = {DW{1'b0}};
                        sbv_d[0] = 1'b0;
                    end else begin
                        sa_d[0]  = a_lane_s;
                        sav_d[0] = inject_s;
                        sb_d[0]  = b_lane_s;
                        sbv_d[0] = inject_s;
                    end
                    for (int s = 1; s < gi; s++) begin
                        if (start_s) begin
                            sa_d[s]  = {DW{1'b0}};
                            sav_d[s] = 1'b0;
                            sb_d[s]  = {DW{1'b0}};
                            sbv_d[s] = 1'b0;
                        end else begin
                            sa_d[s]  = sa_q[s-1];
                            sav_d[s] = sav_q[s-1];
                            sb_d[s]  = sb_q[s-1];
                            sbv_d[s] = sbv_q[s-1];
                        end
                    end
                end

                // Skew delay registers.
                always_ff @(posedge clk or posedge rstn) begin
                    if (rstn) begin
                        for (int s = 0; s < gi; s++) begin
                            sa_q[s]  <= {DW{1'b0}};
                            sav_q[s] <= 1'b0;
                            sb_q[s]  <= {DW{1'b0}};
                            sbv_q[s] <= 1'b0;
                        end
                    end else begin
                        for (int s = 0; s < gi; s++) begin
                            sa_q[s]  <= sa_d[s];
                            sav_q[s] <= sav_d[s];
                            sb_q[s]  <= sb_d[s];
                            sbv_q[s] <= sbv_d[s];
                        end
                    end
                end

                assign a_edge_s[gi]   = sa_q[gi-1];
                assign a_edge_v_s[gi] = sav_q[gi-1];
                assign b_edge_s[gi]   = sb_q[gi-1];
                assign b_edge_v_s[gi] = sbv_q[gi-1];
            end
        end

        for (gi = 0; gi < N; gi++) begin : g_row
            for (gj = 0; gj < N; gj++) begin : g_pe
                logic signed [DW-1:0]   a_q, a_d, a_in_s;
                logic signed [DW-1:0]   b_q, b_d, b_in_s;
                logic                   av_q, av_d, av_in_s;
                logic                   bv_q, bv_d, bv_in_s;
                logic [ACCW-1:0]        acc_q, acc_d;
                logic signed [2*DW-1:0] prod_s;

                if (gj == 0) begin : g_west
                    assign a_in_s  = a_edge_s[gi];
                    assign av_in_s = a_edge_v_s[gi];
                end else begin : g_west
                    assign a_in_s  = a_pe_s[gi][gj-1];
                    assign av_in_s = a_pe_v_s[gi][gj-1];
                end

                if (gi == 0) begin : g_north
                    assign b_in_s  = b_edge_s[gj];
                    assign bv_in_s = b_edge_v_s[gj];
                end else begin : g_north
                    assign b_in_s  = b_pe_s[gi-1][gj];
                    assign bv_in_s = b_pe_v_s[gi-1][gj];
                end

                assign prod_s = a_q * b_q;

                // Operand forwarding and multiply-accumulate, gated by both valid tags.
                always_comb begin
                    if (start_s) begin
                        a_d   = {DW{1'b0}};
                        av_d  = 1'b0;
                        b_d   = {DW{1'b0}};
                        bv_d  = 1'b0;
                        acc_d = {ACCW{1'b0}};
                    end else begin
                        a_d  = a_in_s;
                        av_d = av_in_s;
                        b_d  = b_in_s;
                        bv_d = bv_in_s;
                        if (av_q && bv_q) begin
                            acc_d = acc_q + {{(ACCW-2*DW){prod_s[2*DW-1]}}, prod_s};
                        end else begin
                            acc_d = acc_q;
                        end
                    end
                end

                // PE operand and accumulator registers.
                always_ff @(posedge clk or posedge rstn) begin
                    if (rstn) begin
                        a_q   <= {DW{1'b0}};
                        av_q  <= 1'b0;
                        b_q   <= {DW{1'b0}};
                        bv_q  <= 1'b0;
                        acc_q <= {ACCW{1'b0}};
                    end else begin
                        a_q   <= a_d;
                        av_q  <= av_d;
                        b_q   <= b_d;
                        bv_q  <= bv_d;
                        acc_q <= acc_d;
                    end
                end

                if (gj < N-1) begin : g_east
                    assign a_pe_s[gi][gj]   = a_q;
                    assign a_pe_v_s[gi][gj] = av_q;
                end
                if (gi < N-1) begin : g_south
                    assign b_pe_s[gi][gj]   = b_q;
                    assign b_pe_v_s[gi][gj] = bv_q;
                end
                assign acc_s[gi*N + gj] = acc_q;
            end
        end
    endgenerate

    // Sequencing: load slices, flush the wavefront for 2N-1 cycles, then serve reads.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        idx_d       = idx_q;
        rout_d      = rout_q;
        rvalid_d    = rvalid_q;
        case (state_q)
            S_IDLE: begin
                if (fire) begin
                    state_d     = S_LOAD;
                    drain_cnt_d = {DCW{1'b0}};
                    idx_d       = {IDXW{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (in_valid && in_last) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = {DCW{1'b0}};
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_DRAIN: begin
                // C[0][0] settled long ago; the far corner settles on this same edge.
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d  = S_READ;
                    idx_d    = {IDXW{1'b0}};
                    rout_d   = acc_s[0];
                    rvalid_d = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + DCW'(1);
                end
            end
            S_READ: begin
                if (r_read && rvalid_q) begin
                    if (idx_q == IDX_LAST) begin
                        state_d  = S_IDLE;
                        idx_d    = {IDXW{1'b0}};
                        rout_d   = {ACCW{1'b0}};
                        rvalid_d = 1'b0;
                    end else begin
                        idx_d  = idx_nx_s;
                        rout_d = acc_s[idx_nx_s];
                    end
                end else begin
                    state_d = S_READ;
                end
            end
            default: begin
                state_d  = S_IDLE;
                rout_d   = {ACCW{1'b0}};
                rvalid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q     <= S_IDLE;
            drain_cnt_q <= {DCW{1'b0}};
            idx_q       <= {IDXW{1'b0}};
            rout_q      <= {ACCW{1'b0}};
            rvalid_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            idx_q       <= idx_d;
            rout_q      <= rout_d;
            rvalid_q    <= rvalid_d;
            busy_q      <= busy_d;
        end
    end

    assign routport   = rout_q;
    assign rvalidport = rvalid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_systolic_array_core.sv
// Self-checking bench for systolic_array_core: directed and random matrix products
// compared against a plain triple-loop reference computed in the bench.
module tb_systolic_array_core;
    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int ACCW = 32;
    localparam int KMAX = 16;

    logic              clk = 1'b0;
    logic              rstn;
    logic              fire;
    logic [N*DW-1:0]   a_col;
    logic [N*DW-1:0]   b_row;
    logic              in_valid;
    logic              in_last;
    logic              r_read;
    logic [ACCW-1:0]   routport;
    logic              rvalidport;
    logic              busy;

    int checks = 0;
    int errors = 0;
    int am [N][KMAX];
    int bm [KMAX][N];
    int exp_c [N*N];

    always #5 clk = ~clk;

    systolic_array_core #(.N(N), .DW(DW), .ACCW(ACCW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .fire       (fire),
        .a_col      (a_col),
        .b_row      (b_row),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .r_read     (r_read),
        .routport   (routport),
        .rvalidport (rvalidport),
        .busy       (busy)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic compute_ref(input int k_len);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                int acc;
                acc = 0;
                for (int k = 0; k < k_len; k++) acc += am[i][k] * bm[k][j];
                exp_c[i*N + j] = acc;
            end
        end
    endtask

    task automatic set_identity();
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                am[i][k] = (i == k) ? 1 : 0;
                bm[k][i] = k*N + i + 1;
            end
        end
    endtask

    task automatic drive_slice(input int k);
        int v;
        for (int i = 0; i < N; i++) begin
            v = am[i][k];
            a_col[i*DW +: DW] = v[DW-1:0];
            v = bm[k][i];
            b_row[i*DW +: DW] = v[DW-1:0];
        end
    endtask

    // gap_mode: 0 none, 1 three bubbles, 2 random 0..3 bubbles
    task automatic load_phase(input int k_len, input int gap_mode, input bit noise);
        int gaps;
        fire = 1'b1;
        in_valid = 1'b1;
        in_last = 1'($urandom_range(0, 1));
        a_col = $urandom();
        b_row = $urandom();
        @(negedge clk);
        fire = 1'b0;
        check_val("busy_load", 32'(busy), 32'd1);
        for (int k = 0; k < k_len; k++) begin
            drive_slice(k);
            in_valid = 1'b1;
            in_last = (k == k_len - 1);
            if (noise) fire = 1'b1;
            @(negedge clk);
            fire = 1'b0;
            in_valid = 1'b0;
            in_last = 1'b0;
            if (k < k_len - 1) begin
                gaps = (gap_mode == 1) ? 3 : (gap_mode == 2) ? int'($urandom_range(0, 3)) : 0;
                for (int g = 0; g < gaps; g++) begin
                    a_col = $urandom();
                    b_row = $urandom();
                    in_last = 1'($urandom_range(0, 1));
                    if (noise) r_read = 1'b1;
                    @(negedge clk);
                    r_read = 1'b0;
                    in_last = 1'b0;
                end
            end
        end
    endtask

    task automatic wait_result();
        int cnt;
        cnt = 0;
        check_val("busy_drain", 32'(busy), 32'd1);
        while (rvalidport !== 1'b1 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check_val("drain_latency", 32'(cnt), 32'd7);
    endtask

    task automatic read_all(input int pace, input bit noise);
        for (int idx = 0; idx < N*N; idx++) begin
            check_val($sformatf("rvalid%0d", idx), 32'(rvalidport), 32'd1);
            check_val($sformatf("c%0d", idx), routport, exp_c[idx]);
            for (int p = 1; p < pace; p++) begin
                r_read = 1'b0;
                if (noise) fire = 1'b1;
                @(negedge clk);
                fire = 1'b0;
                check_val($sformatf("hold%0d", idx), routport, exp_c[idx]);
            end
            r_read = 1'b1;
            @(negedge clk);
        end
        r_read = 1'b0;
        check_val("rvalid_end", 32'(rvalidport), 32'd0);
        check_val("rout_end", routport, 32'd0);
        check_val("busy_end", 32'(busy), 32'd0);
    endtask

    task automatic full_run(input int k_len, input int gap_mode, input int pace, input bit noise);
        compute_ref(k_len);
        load_phase(k_len, gap_mode, noise);
        wait_result();
        read_all(pace, noise);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rstn = 1'b1;
        fire = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        r_read = 1'b0;
        a_col = '0;
        b_row = '0;
        repeat (2) @(negedge clk);
        check_val("rst_rout", routport, 32'd0);
        check_val("rst_rvalid", 32'(rvalidport), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        rstn = 1'b0;
        r_read = 1'b1;
        @(negedge clk);
        r_read = 1'b0;
        check_val("idle_read_ignored", 32'(busy), 32'd0);

        // Identity, plain and with bubbles, control noise and paced reads.
        set_identity();
        full_run(4, 0, 1, 1'b0);
        full_run(4, 1, 5, 1'b1);

        // Signed extremes.
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < N; i++) begin
                am[i][k] = -128;
                bm[k][i] = -128;
            end
        full_run(4, 0, 1, 1'b0);
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < N; i++) bm[k][i] = 127;
        full_run(4, 0, 2, 1'b0);

        // Reset during drain, then a clean identity run.
        set_identity();
        load_phase(4, 0, 1'b0);
        repeat (3) @(negedge clk);
        #1 rstn = 1'b1;
        #1;
        check_val("midrst_rvalid", 32'(rvalidport), 32'd0);
        check_val("midrst_rout", routport, 32'd0);
        check_val("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        full_run(4, 0, 1, 1'b0);

        // Single slice.
        for (int i = 0; i < N; i++) begin
            am[i][0] = i + 1;
            bm[0][i] = (i + 1) * 10;
        end
        full_run(1, 0, 1, 1'b0);

        // Random products with random K, bubbles and read pacing.
        for (int r = 0; r < 8; r++) begin
            int k_len;
            k_len = $urandom_range(1, 12);
            for (int k = 0; k < k_len; k++)
                for (int i = 0; i < N; i++) begin
                    am[i][k] = int'($urandom_range(0, 255)) - 128;
                    bm[k][i] = int'($urandom_range(0, 255)) - 128;
                end
            full_run(k_len, 2, int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=%0d exp=%0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule
